trace_line_tx: RTL and testbench
================================

// Module: trace_line_tx
// PURPOSE
//  Transmit side of the interactive-bench text protocol: takes a binary sample
//  and emits the ASCII line "<NAME> <value>\n\n" as a byte stream.
//  Lets a hardware DUT (e.g. a decade counter) report its output over a byte
//  link/UART in the same format the bench parser consumes. One line per sample.
// PARAMETERS
//  WIDTH     4      sample width in bits, 1..16
//  NAME      "OUT"  signal name, packed string, <=8 chars, right-aligned
//  NAME_LEN  3      chars of NAME used, 1..8
//  DIGITS    (lp)   decimal digits of 2**WIDTH-1 (WIDTH=4 -> 2, WIDTH=8 -> 3)
// PORTS
//  CLK           in   1      clock, rising edge
//  RESET_N       in   1      async reset, active-low
//  SAMPLE        in   WIDTH  value to report, unsigned
//  SAMPLE_VALID  in   1      SAMPLE present
//  SAMPLE_READY  out  1      block accepts a sample this cycle
//  TX_DATA       out  8      ASCII byte
//  TX_VALID      out  1      TX_DATA valid
//  TX_READY      in   1      sink takes byte when TX_VALID && TX_READY
//  BUSY          out  1      line in progress (any state but IDLE)
// BEHAVIOUR
//  - Reset (RESET_N low, async): state IDLE, SAMPLE_READY=1, TX_VALID=0,
//    TX_DATA=8'h00, BUSY=0. Any partial line is dropped; no resume.
//  - States: IDLE -> CONV -> NAME -> SP -> DIG -> NL1 -> NL2 -> IDLE.
//  - IDLE: SAMPLE_READY=1. Accept on SAMPLE_VALID&&SAMPLE_READY; latch SAMPLE,
//    go CONV. SAMPLE_READY=0 in every other state (no queueing).
//  - CONV: shift-add-3 binary->BCD, exactly WIDTH cycles, no output.
//  - First TX_VALID in cycle WIDTH+1 after the accept edge.
//  - NAME: NAME_LEN bytes, char i = NAME[8*(NAME_LEN-1-i)+:8], i=0 first.
//  - SP: one 8'h20.
//  - DIG: DIGITS bytes, most significant first, field right-justified:
//    leading zero digits sent as 8'h20; least significant digit always sent
//    as a digit (value 0 -> spaces then "0"). Matches Verilog %d padding.
//  - NL1, NL2: 8'h0A each (value line, then blank terminator line).
//  - Line length = NAME_LEN+1+DIGITS+2 bytes, fixed for all values.
//  - Handshake: each byte state holds TX_VALID=1; advance only on
//    TX_VALID&&TX_READY. TX_DATA stable while TX_VALID&&!TX_READY.
//    TX_VALID never drops before transfer. With TX_READY held 1, one byte per cycle.
//  - After NL2 transfer: IDLE next cycle, TX_VALID=0; earliest next accept
//    that cycle (no back-to-back overlap; min 1 idle cycle between lines).
//  - SAMPLE changes after accept have no effect on the line being sent.
//  - Max value 2**WIDTH-1 must print without overflow (DIGITS sized for it).
// TESTING
//  1 WIDTH=4, SAMPLE=9, TX_READY=1 -> 4F 55 54 20 20 39 0A 0A, first valid
//    5 cycles after accept, 8 consecutive cycles, then SAMPLE_READY=1.
//  2 SAMPLE=0 -> 4F 55 54 20 20 30 0A 0A; SAMPLE=11 -> 4F 55 54 20 31 31 0A 0A;
//    SAMPLE=15 -> ... 31 35 0A 0A.
//  3 TX_READY random 30% -> same byte sequence, TX_DATA stable while stalled,
//    no byte lost or duplicated; SAMPLE_VALID held high meanwhile -> not accepted
//    until IDLE.
//  4 RESET_N low mid-DIG, async (between edges) -> TX_VALID=0 immediately;
//    after release, SAMPLE=3 -> full fresh line 4F 55 54 20 20 33 0A 0A.
//  5 WIDTH=8, NAME="CNT", SAMPLE=200 then 7 -> 43 4E 54 20 32 30 30 0A 0A,
//    then 43 4E 54 20 20 20 37 0A 0A.
//  6 Sweep 0..2**WIDTH-1 for WIDTH=4 against $sformatf("%s %d\n\n") model.

Source files
------------

// File: rtl/trace_line_tx.sv
// Serialises one binary sample per line as ASCII "<NAME> <value>\n\n" over a
// valid/ready byte link; the value is converted to BCD by shift-add-3 first.
module trace_line_tx #(
  parameter int unsigned WIDTH    = 4,
  parameter logic [63:0] NAME     = "OUT",
  parameter int unsigned NAME_LEN = 3
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [WIDTH-1:0] SAMPLE,
  input  logic             SAMPLE_VALID,
  output logic             SAMPLE_READY,
  output logic [7:0]       TX_DATA,
  output logic             TX_VALID,
  input  logic             TX_READY,
  output logic             BUSY
);

  function automatic int unsigned calc_digits(input int unsigned w);
    int unsigned v;
    int unsigned n;
    v = (32'd1 << w) - 32'd1;
    n = 1;
    while (v >= 10) begin
      v = v / 10;
      n = n + 1;
    end
    return n;
  endfunction

  localparam int unsigned DIGITS = calc_digits(WIDTH);
  localparam int unsigned BcdW   = 4 * DIGITS;
  localparam logic [4:0]  ConvLast = 5'(WIDTH - 1);
  localparam logic [4:0]  NameLast = 5'(NAME_LEN - 1);
  localparam logic [4:0]  DigLast  = 5'(DIGITS - 1);

  typedef enum logic [2:0] {StIdle, StConv, StName, StSp, StDig, StNl1, StNl2} state_e;

  state_e            state_q, state_d;
  logic [4:0]        idx_q, idx_d;
  logic [WIDTH-1:0]  bin_q, bin_d;
  logic [BcdW-1:0]   bcd_q, bcd_d, adj;
  logic [BcdW+WIDTH-1:0] dabble;
  logic              seen_q, seen_d;
  logic              xfer;
  logic [3:0]        cur;
  logic              blank;
  logic [2:0]        name_pos;

  assign xfer     = TX_VALID && TX_READY;
  assign cur      = bcd_q[BcdW-1 -: 4];
  // Leading zeros become spaces, but the units digit is always printed.
  assign blank    = (cur == 4'd0) && !seen_q && (idx_q != DigLast);
  assign name_pos = 3'(NAME_LEN - 1) - idx_q[2:0];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (SAMPLE_VALID) state_d = StConv;
      StConv:  if (idx_q == ConvLast) state_d = StName;
      StName:  if (xfer && idx_q == NameLast) state_d = StSp;
      StSp:    if (xfer) state_d = StDig;
      StDig:   if (xfer && idx_q == DigLast) state_d = StNl1;
      StNl1:   if (xfer) state_d = StNl2;
      StNl2:   if (xfer) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    SAMPLE_READY = (state_q == StIdle);
    BUSY         = (state_q != StIdle);
    TX_VALID     = 1'b0;
    TX_DATA      = 8'h00;
    case (state_q)
      StName: begin
        TX_VALID = 1'b1;
        TX_DATA  = NAME[{name_pos, 3'b000} +: 8];
      end
      StSp: begin
        TX_VALID = 1'b1;
        TX_DATA  = 8'h20;
      end
      StDig: begin
        TX_VALID = 1'b1;
        TX_DATA  = blank ? 8'h20 : {4'h3, cur};
      end
      StNl1, StNl2: begin
        TX_VALID = 1'b1;
        TX_DATA  = 8'h0A;
      end
      default: ;
    endcase
  end

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    dabble = {adj, bin_q} << 1;
  end

  always_comb begin
    idx_d  = idx_q;
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    seen_d = seen_q;
    if (state_d != state_q) begin
      idx_d = 5'd0;
    end else if (state_q == StConv || ((state_q == StName || state_q == StDig) && xfer)) begin
      idx_d = idx_q + 5'd1;
    end
    case (state_q)
      StIdle: begin
        if (SAMPLE_VALID) begin
          bin_d  = SAMPLE;
          bcd_d  = '0;
          seen_d = 1'b0;
        end
      end
      StConv: {bcd_d, bin_d} = dabble;
      StDig: begin
        // Current digit is always the top nibble; shift the next one up.
        if (xfer) begin
          bcd_d  = bcd_q << 4;
          seen_d = seen_q || (cur != 4'd0);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      idx_q  <= 5'd0;
      bin_q  <= '0;
      bcd_q  <= '0;
      seen_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      seen_q <= seen_d;
    end
  end

endmodule

// File: tb/tb_trace_line_tx.sv
// Directed bench for trace_line_tx: a 4-bit "OUT" instance and an 8-bit "CNT"
// instance, checking byte streams, latency, stalls and async reset.
module tb_trace_line_tx;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic [3:0] sample4 = '0;
  logic       sv4 = 1'b0, txr4 = 1'b1;
  logic       sr4, txv4, busy4;
  logic [7:0] txd4;
  logic [7:0] sample8 = '0;
  logic       sv8 = 1'b0, txr8 = 1'b1;
  logic       sr8, txv8, busy8;
  logic [7:0] txd8;

  int checks = 0;
  int errors = 0;
  bit wide_sel = 1'b0;
  logic [7:0]   got [0:15];
  logic [127:0] line;

  wire       mon_sr = wide_sel ? sr8 : sr4;
  wire       mon_v  = wide_sel ? txv8 : txv4;
  wire [7:0] mon_d  = wide_sel ? txd8 : txd4;

  trace_line_tx #(.WIDTH(4)) u_dut4 (
    .CLK(CLK), .RESET_N(RESET_N), .SAMPLE(sample4), .SAMPLE_VALID(sv4),
    .SAMPLE_READY(sr4), .TX_DATA(txd4), .TX_VALID(txv4), .TX_READY(txr4), .BUSY(busy4)
  );

  trace_line_tx #(.WIDTH(8), .NAME("CNT"), .NAME_LEN(3)) u_dut8 (
    .CLK(CLK), .RESET_N(RESET_N), .SAMPLE(sample8), .SAMPLE_VALID(sv8),
    .SAMPLE_READY(sr8), .TX_DATA(txd8), .TX_VALID(txv8), .TX_READY(txr8), .BUSY(busy8)
  );

  initial forever #5 CLK = ~CLK;

  // Sends one sample and collects the line; returns timing and handshake stats.
  task automatic run_line(input bit wide, input logic [7:0] v, input int stall_pct,
                          input bit hold, output int n, output int lat, output int span,
                          output int stab_err, output int rdy_err);
    int c, last, len, guard;
    bit prev_stall;
    logic [7:0] prev_data;
    logic rdy;
    wide_sel = wide;
    len = wide ? 9 : 8;
    n = 0; lat = 0; last = 0; stab_err = 0; rdy_err = 0;
    prev_stall = 1'b0; prev_data = 8'h00;
    @(negedge CLK);
    guard = 0;
    while (!mon_sr && guard < 50) begin
      @(negedge CLK);
      guard++;
    end
    if (!mon_sr) begin
      checks++; errors++;
      $display("FAIL accept_timeout sample_ready=%b want 1", mon_sr);
    end
    if (wide) begin sample8 = v; sv8 = 1'b1; end
    else begin sample4 = v[3:0]; sv4 = 1'b1; end
    txr4 = 1'b1; txr8 = 1'b1;
    @(negedge CLK);
    c = 1;
    if (!hold) begin sv4 = 1'b0; sv8 = 1'b0; end
    sample4 = ~v[3:0];
    sample8 = ~v;
    while (n < len && c < 300) begin
      rdy = ($urandom_range(99) >= stall_pct);
      if (wide) txr8 = rdy; else txr4 = rdy;
      if (prev_stall && (!mon_v || mon_d !== prev_data)) stab_err++;
      if (mon_sr) rdy_err++;
      if (mon_v && lat == 0) lat = c;
      if (mon_v && rdy) begin
        got[n] = mon_d;
        n++;
        last = c;
        prev_stall = 1'b0;
      end else begin
        prev_stall = mon_v;
      end
      prev_data = mon_d;
      @(negedge CLK);
      c++;
    end
    txr4 = 1'b1; txr8 = 1'b1;
    span = last - lat;
    line = '0;
    for (int i = 0; i < n; i++) line = {line[119:0], got[i]};
  endtask

  task automatic test_reset();
    repeat (2) @(negedge CLK);
    checks++;
    if (txv4 !== 1'b0) begin errors++; $display("FAIL rst_in_valid got %b want 0", txv4); end
    RESET_N = 1'b1;
    @(negedge CLK);
    checks++;
    if (sr4 !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", sr4); end
    checks++;
    if (txv4 !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", txv4); end
    checks++;
    if (txd4 !== 8'h00) begin errors++; $display("FAIL rst_data got %h want 00", txd4); end
    checks++;
    if (busy4 !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy4); end
  endtask

  task automatic test_basic();
    int n, lat, span, se, re;
    run_line(1'b0, 8'd9, 0, 1'b0, n, lat, span, se, re);
    checks++;
    if (line !== 128'h4F555420_20390A0A || n != 8) begin
      errors++; $display("FAIL basic_line got %h (%0d bytes) want 4f55542020390a0a", line, n);
    end
    checks++;
    if (lat != 5) begin errors++; $display("FAIL basic_latency got %0d want 5", lat); end
    checks++;
    if (span != 7) begin errors++; $display("FAIL basic_span got %0d want 7", span); end
    checks++;
    if (sr4 !== 1'b1 || txv4 !== 1'b0) begin
      errors++; $display("FAIL basic_idle got ready=%b valid=%b want 1 0", sr4, txv4);
    end
  endtask

  task automatic test_values();
    int n, lat, span, se, re;
    logic [7:0]   vals [0:2];
    logic [127:0] exps [0:2];
    vals[0] = 8'd0;  exps[0] = 128'h4F555420_20300A0A;
    vals[1] = 8'd11; exps[1] = 128'h4F555420_31310A0A;
    vals[2] = 8'd15; exps[2] = 128'h4F555420_31350A0A;
    for (int k = 0; k < 3; k++) begin
      run_line(1'b0, vals[k], 0, 1'b0, n, lat, span, se, re);
      checks++;
      if (line !== exps[k]) begin
        errors++; $display("FAIL value_%0d got %h want %h", vals[k], line, exps[k]);
      end
    end
  endtask

  task automatic test_stall();
    int n, lat, span, se, re, g;
    run_line(1'b0, 8'd6, 30, 1'b1, n, lat, span, se, re);
    checks++;
    if (line !== 128'h4F555420_20360A0A) begin
      errors++; $display("FAIL stall_line got %h want 4f55542020360a0a", line);
    end
    checks++;
    if (se != 0) begin errors++; $display("FAIL stall_stable got %0d want 0", se); end
    checks++;
    if (re != 0) begin errors++; $display("FAIL stall_no_accept got %0d want 0", re); end
    checks++;
    if (sr4 !== 1'b1) begin errors++; $display("FAIL stall_idle got %b want 1", sr4); end
    @(negedge CLK);
    sv4 = 1'b0;
    checks++;
    if (busy4 !== 1'b1) begin errors++; $display("FAIL stall_reaccept got %b want 1", busy4); end
    g = 0;
    while (busy4 && g < 100) begin @(negedge CLK); g++; end
    checks++;
    if (busy4 !== 1'b0) begin errors++; $display("FAIL stall_drain got %b want 0", busy4); end
  endtask

  task automatic test_async_reset();
    int n, lat, span, se, re;
    wide_sel = 1'b0;
    @(negedge CLK);
    sample4 = 4'd12; sv4 = 1'b1; txr4 = 1'b1;
    @(negedge CLK);
    sv4 = 1'b0;
    repeat (8) @(negedge CLK);
    checks++;
    if (txv4 !== 1'b1 || txd4 !== 8'h31) begin
      errors++; $display("FAIL ar_middig got valid=%b data=%h want 1 31", txv4, txd4);
    end
    #2 RESET_N = 1'b0;
    #1;
    checks++;
    if (txv4 !== 1'b0 || txd4 !== 8'h00) begin
      errors++; $display("FAIL ar_immediate got valid=%b data=%h want 0 00", txv4, txd4);
    end
    checks++;
    if (busy4 !== 1'b0 || sr4 !== 1'b1) begin
      errors++; $display("FAIL ar_state got busy=%b ready=%b want 0 1", busy4, sr4);
    end
    @(negedge CLK);
    RESET_N = 1'b1;
    run_line(1'b0, 8'd3, 0, 1'b0, n, lat, span, se, re);
    checks++;
    if (line !== 128'h4F555420_20330A0A) begin
      errors++; $display("FAIL ar_fresh got %h want 4f55542020330a0a", line);
    end
  endtask

  task automatic test_wide();
    int n, lat, span, se, re;
    run_line(1'b1, 8'd200, 0, 1'b0, n, lat, span, se, re);
    checks++;
    if (line !== 128'h43_4E5420_3230_300A0A || n != 9) begin
      errors++; $display("FAIL wide_200 got %h (%0d bytes) want 434e542032303 00a0a", line, n);
    end
    checks++;
    if (lat != 9) begin errors++; $display("FAIL wide_latency got %0d want 9", lat); end
    run_line(1'b1, 8'd7, 0, 1'b0, n, lat, span, se, re);
    checks++;
    if (line !== 128'h43_4E5420_2020_370A0A) begin
      errors++; $display("FAIL wide_7 got %h want 434e5420202037 0a0a", line);
    end
  endtask

  task automatic test_sweep();
    int n, lat, span, se, re;
    string s;
    logic [127:0] exp;
    logic [3:0] v4;
    for (int v = 0; v < 16; v++) begin
      v4 = 4'(v);
      s = $sformatf("%s %d\n\n", "OUT", v4);
      exp = '0;
      for (int i = 0; i < s.len(); i++) exp = {exp[119:0], s[i]};
      run_line(1'b0, {4'h0, v4}, 0, 1'b0, n, lat, span, se, re);
      checks++;
      if (line !== exp || n != s.len()) begin
        errors++; $display("FAIL sweep_%0d got %h want %h", v, line, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_stall();
    test_async_reset();
    test_wide();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
